// File: rtl/eco32f_writeback.sv
// eco32f writeback stage: register file write port, load alignment
// and extension, and the load-acknowledge stall.
module eco32f_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_flush,
  input  logic [4:0]  mem_rf_r_addr,
  input  logic        mem_rf_r_we,
  input  logic [31:0] mem_alu_result,
  input  logic        mem_load,
  input  logic [1:0]  mem_load_size,
  input  logic        mem_load_signed,
  input  logic [31:0] dbus_dat,
  input  logic        dbus_ack,
  input  logic        dbus_err,
  output logic [4:0]  wb_rf_r_addr,
  output logic        wb_rf_r_we,
  output logic [31:0] wb_rf_r,
  output logic        wb_stall,
  output logic        wb_bus_err
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  logic [0:0] state;
  logic [4:0] ld_addr;
  logic       ld_we;
  logic [1:0] ld_size;
  logic       ld_signed;
  logic [1:0] ld_off;

  logic        take;
  logic        bus_done;
  logic        idle_stall;
  logic        wait_stall;
  logic [1:0]  al_size;
  logic        al_signed;
  logic [1:0]  al_off;
  logic [7:0]  al_byte;
  logic [15:0] al_half;
  logic [31:0] al_data;

  assign take     = mem_valid & ~mem_flush;
  assign bus_done = dbus_ack | dbus_err;

  assign idle_stall = take & mem_load & ~bus_done;
  assign wait_stall = ~mem_flush & ~bus_done;
  assign wb_stall   = (state == IDLE) ? idle_stall : wait_stall;

  // Alignment inputs come from the live mem stage in IDLE, else latched.
  always_comb begin
    al_size   = ld_size;
    al_signed = ld_signed;
    al_off    = ld_off;
    if (state == IDLE) begin
      al_size   = mem_load_size;
      al_signed = mem_load_signed;
      al_off    = mem_alu_result[1:0];
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    al_byte = dbus_dat[7:0];
    unique case (al_off)
      2'd0:    al_byte = dbus_dat[31:24];
      2'd1:    al_byte = dbus_dat[23:16];
      2'd2:    al_byte = dbus_dat[15:8];
      default: al_byte = dbus_dat[7:0];
    endcase
  end

  assign al_half = al_off[1] ? dbus_dat[15:0] : dbus_dat[31:16];

  always_comb begin
    al_data = dbus_dat;
    unique case (al_size)
      2'b10:   al_data = {{24{al_signed & al_byte[7]}}, al_byte};
      2'b01:   al_data = {{16{al_signed & al_half[15]}}, al_half};
      default: al_data = dbus_dat;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ld_addr      <= 5'd0;
      ld_we        <= 1'b0;
      ld_size      <= 2'b00;
      ld_signed    <= 1'b0;
      ld_off       <= 2'b00;
      wb_rf_r_addr <= 5'd0;
      wb_rf_r_we   <= 1'b0;
      wb_rf_r      <= 32'd0;
      wb_bus_err   <= 1'b0;
    end else begin
      wb_rf_r_we <= 1'b0;
      wb_bus_err <= 1'b0;
      if (state == IDLE) begin
        if (take && !mem_load) begin
          wb_rf_r_addr <= mem_rf_r_addr;
          wb_rf_r      <= mem_alu_result;
          wb_rf_r_we   <= mem_rf_r_we & (mem_rf_r_addr != 5'd0);
        end else if (take && dbus_err) begin
          wb_bus_err <= 1'b1;
        end else if (take && dbus_ack) begin
          wb_rf_r_addr <= mem_rf_r_addr;
          wb_rf_r      <= al_data;
          wb_rf_r_we   <= mem_rf_r_we & (mem_rf_r_addr != 5'd0);
        end else if (take) begin
          ld_addr   <= mem_rf_r_addr;
          ld_we     <= mem_rf_r_we;
          ld_size   <= mem_load_size;
          ld_signed <= mem_load_signed;
          ld_off    <= mem_alu_result[1:0];
          state     <= WAIT_ACK;
        end
      end else begin
        if (mem_flush) begin
          state <= IDLE;
        end else if (dbus_err) begin
          wb_bus_err <= 1'b1;
          state      <= IDLE;
        end else if (dbus_ack) begin
          wb_rf_r_addr <= ld_addr;
          wb_rf_r      <= al_data;
          wb_rf_r_we   <= ld_we & (ld_addr != 5'd0);
          state        <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_eco32f_writeback.sv
// Randomized and directed bench for eco32f_writeback against a
// cycle-level reference model of the writeback rules.
module tb_eco32f_writeback;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_flush;
  logic [4:0]  mem_rf_r_addr;
  logic        mem_rf_r_we;
  logic [31:0] mem_alu_result;
  logic        mem_load;
  logic [1:0]  mem_load_size;
  logic        mem_load_signed;
  logic [31:0] dbus_dat;
  logic        dbus_ack;
  logic        dbus_err;
  logic [4:0]  wb_rf_r_addr;
  logic        wb_rf_r_we;
  logic [31:0] wb_rf_r;
  logic        wb_stall;
  logic        wb_bus_err;

  int errors;
  int checks;

  // reference model state
  bit          m_wait;
  logic [4:0]  m_addr;
  bit          m_we;
  logic [1:0]  m_size;
  bit          m_sgn;
  logic [1:0]  m_off;
  bit          e_we;
  bit          e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_dat;

  eco32f_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .mem_valid       (mem_valid),
    .mem_flush       (mem_flush),
    .mem_rf_r_addr   (mem_rf_r_addr),
    .mem_rf_r_we     (mem_rf_r_we),
    .mem_alu_result  (mem_alu_result),
    .mem_load        (mem_load),
    .mem_load_size   (mem_load_size),
    .mem_load_signed (mem_load_signed),
    .dbus_dat        (dbus_dat),
    .dbus_ack        (dbus_ack),
    .dbus_err        (dbus_err),
    .wb_rf_r_addr    (wb_rf_r_addr),
    .wb_rf_r_we      (wb_rf_r_we),
    .wb_rf_r         (wb_rf_r),
    .wb_stall        (wb_stall),
    .wb_bus_err      (wb_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] dat,
                                           input logic [1:0] sz,
                                           input logic [1:0] off,
                                           input bit sg);
    longint unsigned v;
    longint unsigned d;
    int unsigned     o;
    d = dat;
    o = off;
    if (sz == 2'b10) begin
      v = (d >> (8 * (3 - o))) % 256;
      if (sg && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (o >= 2) ? (d % 65536) : (d / 65536);
      if (sg && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = d;
    end
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_wait = 0; m_addr = 0; m_we = 0; m_size = 0; m_sgn = 0; m_off = 0;
    e_we = 0; e_err = 0; e_addr = 0; e_dat = 0;
  endtask

  // One pipeline cycle: drive, check stall, clock, check registered outputs.
  task automatic step(input bit v, input bit fl, input logic [4:0] a,
                      input bit we, input logic [31:0] alu, input bit ld,
                      input logic [1:0] sz, input bit sg,
                      input logic [31:0] dat, input bit ack, input bit err);
    bit exp_stall;
    mem_valid = v; mem_flush = fl; mem_rf_r_addr = a; mem_rf_r_we = we;
    mem_alu_result = alu; mem_load = ld; mem_load_size = sz;
    mem_load_signed = sg; dbus_dat = dat; dbus_ack = ack; dbus_err = err;
    #1;
    if (fl) exp_stall = 0;
    else if (m_wait) exp_stall = !(ack || err);
    else exp_stall = v && ld && !(ack || err);
    chk("stall", {31'd0, wb_stall}, {31'd0, exp_stall});
    @(posedge clk);
    e_we = 0;
    e_err = 0;
    if (fl) begin
      m_wait = 0;
    end else if (!m_wait) begin
      if (v && !ld) begin
        e_we = we && (a != 5'd0); e_addr = a; e_dat = alu;
      end else if (v && err) begin
        e_err = 1;
      end else if (v && ack) begin
        e_we = we && (a != 5'd0); e_addr = a;
        e_dat = ref_load(dat, sz, alu[1:0], sg);
      end else if (v) begin
        m_wait = 1; m_addr = a; m_we = we; m_size = sz; m_sgn = sg;
        m_off = alu[1:0];
      end
    end else if (err) begin
      e_err = 1; m_wait = 0;
    end else if (ack) begin
      e_we = m_we && (m_addr != 5'd0); e_addr = m_addr;
      e_dat = ref_load(dat, m_size, m_off, m_sgn);
      m_wait = 0;
    end
    #1;
    chk("we", {31'd0, wb_rf_r_we}, {31'd0, e_we});
    chk("bus_err", {31'd0, wb_bus_err}, {31'd0, e_err});
    if (e_we) begin
      chk("addr", {27'd0, wb_rf_r_addr}, {27'd0, e_addr});
      chk("data", wb_rf_r, e_dat);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, {31'd0, wb_rf_r_we}, 32'd0);
    chk({tag, "_addr"}, {27'd0, wb_rf_r_addr}, 32'd0);
    chk({tag, "_data"}, wb_rf_r, 32'd0);
    chk({tag, "_err"}, {31'd0, wb_bus_err}, 32'd0);
    chk({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    rst = 0;
    mem_valid = 0; mem_flush = 0; mem_rf_r_addr = 0; mem_rf_r_we = 0;
    mem_alu_result = 0; mem_load = 0; mem_load_size = 0;
    mem_load_signed = 0; dbus_dat = 0; dbus_ack = 0; dbus_err = 0;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    // ALU writes, and $0 suppression
    step(1, 0, 7, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    idle();

    // same-cycle ack byte loads
    step(1, 0, 5, 1, 32'h0000_1001, 1, 2'b10, 1, 32'h11F2_3344, 1, 0);
    chk("ldb_s", wb_rf_r, 32'hFFFF_FFF2);
    step(1, 0, 6, 1, 32'h0000_1001, 1, 2'b10, 0, 32'h11F2_3344, 1, 0);
    chk("ldbu", wb_rf_r, 32'h0000_00F2);

    // half load with three stall cycles, then back-to-back ALU op
    step(1, 0, 9, 1, 32'h0000_2002, 1, 2'b01, 1, 0, 0, 0);
    step(1, 0, 9, 1, 32'h0000_2002, 1, 2'b01, 1, 0, 0, 0);
    step(1, 0, 9, 1, 32'h0000_2002, 1, 2'b01, 1, 0, 0, 0);
    step(1, 0, 9, 1, 32'h0000_2002, 1, 2'b01, 1, 32'h0000_8001, 1, 0);
    chk("ldh_s", wb_rf_r, 32'hFFFF_8001);
    step(1, 0, 4, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0);

    // bus error in WAIT_ACK
    step(1, 0, 8, 1, 32'h0000_0000, 1, 2'b00, 0, 0, 0, 0);
    step(1, 0, 8, 1, 32'h0000_0000, 1, 2'b00, 0, 32'hFFFF_FFFF, 0, 1);
    idle();

    // flush in WAIT_ACK with ack high, then normal ALU op
    step(1, 0, 10, 1, 32'h0000_0003, 1, 2'b10, 0, 0, 0, 0);
    step(1, 1, 10, 1, 32'h0000_0003, 1, 2'b10, 0, 32'h1234_5678, 1, 0);
    step(1, 0, 3, 1, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
    chk("post_flush", wb_rf_r, 32'hA5A5_A5A5);

    // reset in WAIT_ACK, late ack afterwards
    step(1, 0, 11, 1, 32'h0000_0000, 1, 2'b00, 0, 0, 0, 0);
    mem_valid = 0;
    rst = 0;
    #1;
    check_zero("mid_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    step(0, 0, 11, 1, 0, 1, 2'b00, 0, 32'h7777_7777, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           5'($urandom_range(0, 31)), $urandom_range(0, 7) != 0,
           $urandom, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eco32f_writeback.md
# eco32f_writeback

Writeback stage of the eco32f pipeline. It is the write side of the register file. It takes completed memory-stage instructions (ALU results or data-bus loads), aligns and sign/zero-extends load data, and drives the registered `wb_rf_r_addr`/`wb_rf_r_we`/`wb_rf_r` write port. The register file also uses that port as its memory-stage bypass source. While a load waits for its bus acknowledge, the block holds the pipeline with a stall request.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `mem_valid`  in  1  mem stage presents an instruction this cycle
- `mem_flush`  in  1  kill mem-stage instruction and any pending load (exception/branch)
- `mem_rf_r_addr`  in  5  destination register
- `mem_rf_r_we`  in  1  instruction writes a register
- `mem_alu_result`  in  32  ALU result; for loads, effective address (bits [1:0] used)
- `mem_load`  in  1  instruction is a load
- `mem_load_size`  in  2  00 word, 01 half, 10 byte, 11 treated as word
- `mem_load_signed`  in  1  sign-extend (ldh/ldb) vs zero-extend (ldhu/ldbu)
- `dbus_dat`  in  32  data-bus read data, valid with `dbus_ack`
- `dbus_ack`  in  1  data-bus read complete
- `dbus_err`  in  1  data-bus error; completes the access with no write
- `wb_rf_r_addr`  out  5  register file write address (registered)
- `wb_rf_r_we`  out  1  register file write enable (registered)
- `wb_rf_r`  out  32  register file write data (registered)
- `wb_stall`  out  1  combinational stall request to earlier stages
- `wb_bus_err`  out  1  one-cycle pulse: load terminated by `dbus_err`

## Operation
- States: IDLE, WAIT_ACK.
- IDLE, `mem_valid & !mem_flush & !mem_load`: capture `mem_alu_result` and `mem_rf_r_addr`. Next cycle `wb_rf_r_we = mem_rf_r_we & (mem_rf_r_addr != 0)`.
- IDLE, valid load with `dbus_ack` in the same cycle: write the aligned `dbus_dat` next cycle. No stall.
- IDLE, valid load without ack or err: latch addr, we, size, signed, offset `mem_alu_result[1:0]`. Enter WAIT_ACK. `wb_stall` is high this cycle.
- WAIT_ACK: `wb_stall = !(dbus_ack | dbus_err)`.
  - On ack: write aligned data next cycle, return to IDLE.
  - On err: no write, `wb_bus_err` pulse next cycle, return to IDLE.
- `mem_flush` has priority over everything.
  - In IDLE: no write.
  - In WAIT_ACK: return to IDLE, no write, no stall; `dbus_ack`/`dbus_err` that cycle are ignored.
- Both `dbus_ack` and `dbus_err` high: err wins.
- Alignment is big-endian.
  - Byte offset 0 selects bits [31:24], offset 3 selects [7:0].
  - Half offset bit1=0 selects [31:16], bit1=1 selects [15:0]. Offset bit0 is ignored for halfwords (misalignment is trapped in mem stage).
  - Word loads pass through unchanged.
- Extension: signed replicates the selected MSB into the upper bits; unsigned zero-fills.
- Register $0 is never written. `wb_rf_r_we` is forced 0 when the address is 0.
- Cycles with no valid, unflushed instruction (bubbles) give `wb_rf_r_we = 0`. `wb_rf_r`/`wb_rf_r_addr` keep their last value.

## Timing
- Reset (async, `rst` low):
  - state IDLE
  - `wb_rf_r_we = 0`, `wb_rf_r_addr = 0`, `wb_rf_r = 0`
  - `wb_bus_err = 0`, `wb_stall = 0`
- Reset during WAIT_ACK aborts the load. No write occurs after release.
- Latency:
  - ALU result: 1 cycle mem→wb.
  - Load: 1 cycle after the `dbus_ack` cycle.
- `wb_rf_r_we` is high for exactly one cycle per retired writing instruction.
- `wb_stall` is purely combinational from state, `mem_valid`, `mem_load`, `mem_flush`, `dbus_ack`, `dbus_err`. No register sits in that path.
- Back-to-back: an ALU op in the cycle after an acked load is accepted without a bubble. Writes occur on consecutive cycles.

## Test plan
- ALU op, addr 7, result 0x12345678 → next cycle `wb_rf_r_we=1`, addr 7, data 0x12345678. Same with addr 0 → `wb_rf_r_we=0`.
- Signed byte load, offset 1, `dbus_dat=0x11F23344`, ack same cycle → data 0xFFFFFFF2. Unsigned → 0x000000F2. No stall.
- Signed half load, offset 2, `dbus_dat=0x00008001`, ack after 3 wait cycles → `wb_stall` high 3 cycles then low in the ack cycle. Write 0xFFFF8001 one cycle later.
- Load in WAIT_ACK, `dbus_err` asserted → no write, `wb_bus_err` single pulse, state IDLE, stall drops in the err cycle.
- `mem_flush` during WAIT_ACK while `dbus_ack` is high → no write, no stall, next ALU op (addr 3, 0xA5A5A5A5) writes normally.
- `rst` asserted low mid-WAIT_ACK → all outputs 0 immediately. After release, a late `dbus_ack` causes no write.
